e203_exu_wbck_arb: RTL and testbench

Parametrised write-back arbiter in the EXU that merges CH_NUM result channels (ALU, long-pipe units such as LSU/MULDIV) into one registered write-back port toward the regfile. Long-pipe channels retire strictly in OITF order by itag match against the OITF head; short-pipe channels bypass the OITF check. A one-entry output register decouples the regfile side. OITF retirement is signalled only when a long-pipe result leaves the output register.

---
 rtl/e203_exu_wbck_arb_pkg.sv | 14 +
 rtl/e203_exu_wbck_rrarb.sv | 33 +++
 rtl/e203_exu_wbck_arb.sv | 134 +++++++++++++
 tb/tb_e203_exu_wbck_arb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/e203_exu_wbck_arb_pkg.sv
// Shared defaults and helpers for the EXU write-back arbiter.
// Optional round-robin short-pipe arbitration: E203_WBCK_RR_EN.
package e203_exu_wbck_arb_pkg;

    localparam int WBCK_CH_NUM    = 2;
    localparam int E203_XLEN      = 32;
    localparam int E203_RFIDX_W   = 5;
    localparam int E203_ITAG_W    = 1;

    function automatic int chid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/e203_exu_wbck_rrarb.sv
// Round-robin one-hot grant for short-pipe write-back requests.
// Built only when E203_WBCK_RR_EN is defined.
`ifdef E203_WBCK_RR_EN
module e203_exu_wbck_rrarb
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int PW = chid_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] idx;
    logic          found;

    // Scan starting at the pointer, wrapping back to channel 0.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/e203_exu_wbck_arb.sv
// EXU write-back arbiter: OITF-ordered long-pipe, bypassing short-pipe.
// Define E203_WBCK_RR_EN for round-robin short-pipe arbitration.
module e203_exu_wbck_arb
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int CH_NUM  = WBCK_CH_NUM,
    parameter int XLEN    = E203_XLEN,
    parameter int RFIDX_W = E203_RFIDX_W,
    parameter int ITAG_W  = E203_ITAG_W,
    localparam int CW     = chid_w(CH_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CH_NUM-1:0]         wbck_i_valid,
    output logic [CH_NUM-1:0]         wbck_i_ready,
    input  logic [CH_NUM*XLEN-1:0]    wbck_i_wdat,
    input  logic [CH_NUM*RFIDX_W-1:0] wbck_i_rdidx,
    input  logic [CH_NUM*ITAG_W-1:0]  wbck_i_itag,
    input  logic [CH_NUM-1:0]         wbck_i_longp,
    input  logic                      oitf_empty,
    input  logic [ITAG_W-1:0]         oitf_ret_ptr,
    output logic                      oitf_ret_ena,
    output logic                      wbck_o_valid,
    input  logic                      wbck_o_ready,
    output logic [XLEN-1:0]           wbck_o_wdat,
    output logic [RFIDX_W-1:0]        wbck_o_rdidx,
    output logic [CW-1:0]             wbck_o_chid
);

    logic               o_valid;
    logic               o_longp;
    logic [XLEN-1:0]    o_wdat;
    logic [RFIDX_W-1:0] o_rdidx;
    logic [CW-1:0]      o_chid;

    logic [CH_NUM-1:0]  elig;
    logic [CH_NUM-1:0]  long_elig;
    logic [CH_NUM-1:0]  short_elig;
    logic [CH_NUM-1:0]  long_gnt;
    logic [CH_NUM-1:0]  short_gnt;
    logic [CH_NUM-1:0]  grant;
    logic [CW-1:0]      gnt_idx;
    logic [XLEN-1:0]    gnt_wdat;
    logic [RFIDX_W-1:0] gnt_rdidx;
    logic               gnt_longp;
    logic               held_long;
    logic               load_en;
    logic               accept;

    assign held_long = o_valid & o_longp;
    assign load_en   = ~o_valid | wbck_o_ready;

    // A held long-pipe entry blocks further long-pipe grants until it retires.
    always_comb begin
        elig = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            elig[i] = wbck_i_valid[i] & (~wbck_i_longp[i] |
                      ((wbck_i_itag[i*ITAG_W +: ITAG_W] == oitf_ret_ptr) &
                       ~oitf_empty & ~held_long));
        end
    end

    assign long_elig  = elig & wbck_i_longp;
    assign short_elig = elig & ~wbck_i_longp;
    assign long_gnt   = long_elig & (~long_elig + CH_NUM'(1));

`ifdef E203_WBCK_RR_EN
    logic [CW-1:0] rr_ptr;

    e203_exu_wbck_rrarb #(
        .N(CH_NUM)
    ) u_rrarb (
        .req(short_elig),
        .ptr(rr_ptr),
        .gnt(short_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept & ~gnt_longp) begin
            rr_ptr <= (gnt_idx == CW'(CH_NUM - 1)) ? '0 : gnt_idx + CW'(1);
        end
    end
`else
    assign short_gnt = short_elig & (~short_elig + CH_NUM'(1));
`endif

    assign grant = (|long_elig) ? long_gnt : short_gnt;

    always_comb begin
        gnt_idx   = '0;
        gnt_wdat  = '0;
        gnt_rdidx = '0;
        gnt_longp = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (grant[i]) begin
                gnt_idx   = CW'(i);
                gnt_wdat  = wbck_i_wdat[i*XLEN +: XLEN];
                gnt_rdidx = wbck_i_rdidx[i*RFIDX_W +: RFIDX_W];
                gnt_longp = wbck_i_longp[i];
            end
        end
    end

    // Nothing is accepted while reset is asserted.
    assign accept       = (|grant) & load_en & ~rst;
    assign wbck_i_ready = grant & {CH_NUM{load_en & ~rst}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_longp <= 1'b0;
            o_wdat  <= '0;
            o_rdidx <= '0;
            o_chid  <= '0;
        end else if (accept) begin
            o_valid <= 1'b1;
            o_longp <= gnt_longp;
            o_wdat  <= gnt_wdat;
            o_rdidx <= gnt_rdidx;
            o_chid  <= gnt_idx;
        end else if (o_valid & wbck_o_ready) begin
            o_valid <= 1'b0;
        end
    end

    assign oitf_ret_ena = held_long & wbck_o_ready;
    assign wbck_o_valid = o_valid;
    assign wbck_o_wdat  = o_wdat;
    assign wbck_o_rdidx = o_rdidx;
    assign wbck_o_chid  = o_chid;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Randomized bench for e203_exu_wbck_arb against a behavioural model.
// Model follows E203_WBCK_RR_EN the same way the RTL build does.
module tb_e203_exu_wbck_arb;

    localparam int CH = 3;
    localparam int XL = 32;
    localparam int RW = 5;
    localparam int TW = 1;
    localparam int CW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CH-1:0]    wbck_i_valid = '0;
    logic [CH-1:0]    wbck_i_ready;
    logic [CH*XL-1:0] wbck_i_wdat = '0;
    logic [CH*RW-1:0] wbck_i_rdidx = '0;
    logic [CH*TW-1:0] wbck_i_itag = '0;
    logic [CH-1:0]    wbck_i_longp = '0;
    logic             oitf_empty = 1'b0;
    logic [TW-1:0]    oitf_ret_ptr = '0;
    logic             oitf_ret_ena;
    logic             wbck_o_valid;
    logic             wbck_o_ready = 1'b1;
    logic [XL-1:0]    wbck_o_wdat;
    logic [RW-1:0]    wbck_o_rdidx;
    logic [CW-1:0]    wbck_o_chid;

    int total = 0;
    int bad   = 0;

    // Reference state: one held write-back and the round-robin start point.
    bit          m_v;
    bit          m_lp;
    logic [31:0] m_wdat;
    logic [4:0]  m_rdidx;
    int          m_chid;
    int          m_ptr;

    always #5 clk = ~clk;

    e203_exu_wbck_arb #(
        .CH_NUM(CH),
        .XLEN(XL),
        .RFIDX_W(RW),
        .ITAG_W(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wbck_i_valid(wbck_i_valid),
        .wbck_i_ready(wbck_i_ready),
        .wbck_i_wdat(wbck_i_wdat),
        .wbck_i_rdidx(wbck_i_rdidx),
        .wbck_i_itag(wbck_i_itag),
        .wbck_i_longp(wbck_i_longp),
        .oitf_empty(oitf_empty),
        .oitf_ret_ptr(oitf_ret_ptr),
        .oitf_ret_ena(oitf_ret_ena),
        .wbck_o_valid(wbck_o_valid),
        .wbck_o_ready(wbck_o_ready),
        .wbck_o_wdat(wbck_o_wdat),
        .wbck_o_rdidx(wbck_o_rdidx),
        .wbck_o_chid(wbck_o_chid)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_ch(input int i, input bit v, input bit lp,
                          input bit tag, input logic [31:0] d,
                          input logic [4:0] rd);
        wbck_i_valid[i]          = v;
        wbck_i_longp[i]          = lp;
        wbck_i_itag[i]           = tag;
        wbck_i_wdat[i*XL +: XL]  = d;
        wbck_i_rdidx[i*RW +: RW] = rd;
    endtask

    task automatic model_reset();
        m_v     = 0;
        m_lp    = 0;
        m_wdat  = '0;
        m_rdidx = '0;
        m_chid  = 0;
        m_ptr   = 0;
    endtask

    // Picks the winner from the rules: an eligible long-pipe beats any
    // short-pipe; short-pipe ties resolved by priority or rotation.
    function automatic int pick_winner();
        int win = -1;
        bit e[CH];
        for (int i = 0; i < CH; i++) begin
            e[i] = wbck_i_valid[i] && (!wbck_i_longp[i] ||
                   (wbck_i_itag[i] == oitf_ret_ptr[0] && !oitf_empty &&
                    !(m_v && m_lp)));
        end
        for (int i = 0; i < CH; i++)
            if (win < 0 && e[i] && wbck_i_longp[i]) win = i;
        if (win < 0) begin
`ifdef E203_WBCK_RR_EN
            for (int k = 0; k < CH; k++) begin
                int j = (m_ptr + k) % CH;
                if (win < 0 && e[j] && !wbck_i_longp[j]) win = j;
            end
`else
            for (int i = 0; i < CH; i++)
                if (win < 0 && e[i] && !wbck_i_longp[i]) win = i;
`endif
        end
        return win;
    endfunction

    // One cycle: check settled outputs, then advance the model at the edge.
    task automatic step();
        int win;
        bit le;
        logic [CH-1:0] exp_rdy;
        #1;
        win = pick_winner();
        le  = !m_v || wbck_o_ready;
        exp_rdy = (win >= 0 && le) ? CH'(1 << win) : '0;
        chk("ready", 64'(wbck_i_ready), 64'(exp_rdy));
        chk("ret_ena", 64'(oitf_ret_ena), 64'(m_v && m_lp && wbck_o_ready));
        chk("o_valid", 64'(wbck_o_valid), 64'(m_v));
        chk("o_wdat", 64'(wbck_o_wdat), 64'(m_wdat));
        chk("o_rdidx", 64'(wbck_o_rdidx), 64'(m_rdidx));
        chk("o_chid", 64'(wbck_o_chid), 64'(m_chid));
        @(posedge clk);
        if (win >= 0 && le) begin
            m_v     = 1;
            m_lp    = wbck_i_longp[win];
            m_wdat  = wbck_i_wdat[win*XL +: XL];
            m_rdidx = wbck_i_rdidx[win*RW +: RW];
            m_chid  = win;
            if (!m_lp) m_ptr = (win + 1) % CH;
        end else if (m_v && wbck_o_ready) begin
            m_v = 0;
        end
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(wbck_o_valid), 64'd0);
        chk({tag, "_ready"}, 64'(wbck_i_ready), 64'd0);
        chk({tag, "_ret"}, 64'(oitf_ret_ena), 64'd0);
        chk({tag, "_wdat"}, 64'(wbck_o_wdat), 64'd0);
        chk({tag, "_rdidx"}, 64'(wbck_o_rdidx), 64'd0);
        chk({tag, "_chid"}, 64'(wbck_o_chid), 64'd0);
    endtask

    initial begin
        model_reset();
        set_ch(0, 1, 0, 0, 32'h1234, 5'd5);
        set_ch(1, 1, 0, 0, 32'h2222, 5'd6);
        set_ch(2, 1, 0, 0, 32'h3333, 5'd7);
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b0;
        step();
        chk("first_wdat", 64'(wbck_o_wdat), 64'h1234);
        chk("first_rdidx", 64'(wbck_o_rdidx), 64'd5);
        // Continuous short traffic: grant order per arbitration mode.
        repeat (4) step();

        // Long ch1 waits for the OITF head to reach its itag.
        set_ch(0, 0, 0, 0, 0, 0);
        set_ch(2, 0, 0, 0, 0, 0);
        set_ch(1, 1, 1, 1, 32'hbeef, 5'd9);
        oitf_ret_ptr = 1'b0;
        repeat (10) step();
        oitf_ret_ptr = 1'b1;
        step();
        set_ch(1, 0, 0, 0, 0, 0);
        step();
        oitf_ret_ptr = 1'b0;
        repeat (2) step();

        // OITF empty blocks a matching long-pipe request.
        set_ch(2, 1, 1, 0, 32'hcafe, 5'd3);
        oitf_empty = 1'b1;
        repeat (3) step();
        oitf_empty = 1'b0;
        step();
        set_ch(2, 0, 0, 0, 0, 0);
        oitf_ret_ptr = 1'b1;

        // Output stall with an entry held, then drain plus reload.
        set_ch(0, 1, 0, 0, 32'h5555, 5'd1);
        step();
        wbck_o_ready = 1'b0;
        repeat (3) step();
        wbck_o_ready = 1'b1;
        repeat (2) step();

        // Short ch0 and matching long ch1 together.
        set_ch(1, 1, 1, 1, 32'h7777, 5'd2);
        step();
        set_ch(1, 0, 0, 0, 0, 0);
        repeat (3) step();

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < CH; i++)
                set_ch(i, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                       $urandom, 5'($urandom));
            oitf_empty   = $urandom_range(0, 4) == 0;
            oitf_ret_ptr = 1'($urandom);
            wbck_o_ready = $urandom_range(0, 3) != 0;
            step();
        end

        // Reset while a long-pipe entry is held.
        set_ch(0, 0, 0, 0, 0, 0);
        set_ch(2, 0, 0, 0, 0, 0);
        set_ch(1, 1, 1, 0, 32'habcd, 5'd4);
        oitf_empty   = 1'b0;
        oitf_ret_ptr = 1'b0;
        wbck_o_ready = 1'b0;
        repeat (2) step();
        wbck_o_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
